cba_seq_adder_ctrl: RTL and testbench

CBA_SEQ_ADDER_CTRL -- requirements
Module: cba_seq_adder_ctrl

---
 rtl/cba_pkg.sv | 12 +
 rtl/cba_slice4.sv | 30 +++
 rtl/cba_seq_adder_ctrl.sv | 119 +++++++++++
 tb/tb_cba_seq_adder_ctrl.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/cba_pkg.sv
// Shared types and constants for the sequential carry-bypass adder controller.
package cba_pkg;

    localparam int unsigned NIB_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

endpackage

// File: rtl/cba_slice4.sv
// 4-bit carry-bypass adder slice: ripple sum, with the carry-out taken straight
// from ci when every bit propagates.
module cba_slice4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       ci,
    output logic [3:0] s,
    output logic       co,
    output logic       byp
);

    logic [3:0] p;
    logic [3:0] g;
    logic       cr;

    assign p   = a ^ b;
    assign g   = a & b;
    assign byp = &p;

    always_comb begin
        s  = '0;
        cr = ci;
        for (int unsigned i = 0; i < 4; i++) begin
            s[i] = p[i] ^ cr;
            cr   = g[i] | (p[i] & cr);
        end
        co = byp ? ci : cr;
    end

endmodule

// File: rtl/cba_seq_adder_ctrl.sv
// Sequential WIDTH-bit adder that time-shares one cba_slice4 over WIDTH/4 cycles.
// Optional subtract support (port sub) is enabled by defining CBA_SEQ_SUB_EN.
module cba_seq_adder_ctrl
    import cba_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic [WIDTH-1:0]                   a,
    input  logic [WIDTH-1:0]                   b,
    input  logic                               cin,
`ifdef CBA_SEQ_SUB_EN
    input  logic                               sub,
`endif
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [WIDTH-1:0]                   sum,
    output logic                               cout,
    output logic [$clog2(WIDTH/NIB_W+1)-1:0]   bypass_cnt
);

    localparam int unsigned NIB  = WIDTH / NIB_W;
    localparam int unsigned IW   = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [IW-1:0] LAST = IW'(NIB - 1);

    state_t           state;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             carry;
    logic [IW-1:0]    idx;

    logic [WIDTH-1:0] b_eff;
    logic             cin_eff;
    logic [3:0]       sl_a;
    logic [3:0]       sl_b;
    logic [3:0]       sl_s;
    logic             sl_co;
    logic             sl_byp;

    // Subtraction is a + ~b + 1, so it reuses the adder path unchanged.
    always_comb begin
        b_eff   = b;
        cin_eff = cin;
`ifdef CBA_SEQ_SUB_EN
        if (sub) begin
            b_eff   = ~b;
            cin_eff = 1'b1;
        end
`endif
    end

    assign sl_a = a_q[NIB_W*idx +: NIB_W];
    assign sl_b = b_q[NIB_W*idx +: NIB_W];

    cba_slice4 u_slice (
        .a   (sl_a),
        .b   (sl_b),
        .ci  (carry),
        .s   (sl_s),
        .co  (sl_co),
        .byp (sl_byp)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            in_ready   <= 1'b1;
            out_valid  <= 1'b0;
            sum        <= '0;
            cout       <= 1'b0;
            bypass_cnt <= '0;
            idx        <= '0;
            carry      <= 1'b0;
            a_q        <= '0;
            b_q        <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_q        <= a;
                        b_q        <= b_eff;
                        carry      <= cin_eff;
                        idx        <= '0;
                        sum        <= '0;
                        bypass_cnt <= '0;
                        cout       <= 1'b0;
                        in_ready   <= 1'b0;
                        state      <= RUN;
                    end
                end
                RUN: begin
                    sum[NIB_W*idx +: NIB_W] <= sl_s;
                    carry                   <= sl_co;
                    idx                     <= idx + 1'b1;
                    if (sl_byp) begin
                        bypass_cnt <= bypass_cnt + 1'b1;
                    end
                    if (idx == LAST) begin
                        cout      <= sl_co;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cba_seq_adder_ctrl.sv
// Self-checking bench for cba_seq_adder_ctrl (WIDTH=16, addition-only build).
module tb_cba_seq_adder_ctrl;

    localparam int unsigned WIDTH = 16;
    localparam int unsigned NIB   = WIDTH / 4;
    localparam int unsigned BW    = $clog2(NIB + 1);

    logic             clk       = 1'b0;
    logic             rst       = 1'b1;
    logic             in_valid  = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] a         = '0;
    logic [WIDTH-1:0] b         = '0;
    logic             cin       = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic [BW-1:0]    bypass_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    cba_seq_adder_ctrl #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .a          (a),
        .b          (b),
        .cin        (cin),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .sum        (sum),
        .cout       (cout),
        .bypass_cnt (bypass_cnt)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Transaction-level model: result from plain arithmetic, timing as a countdown.
    int               m_left  = 0;
    bit               m_done  = 0;
    bit               m_clean = 0;
    bit               started = 0;
    logic [WIDTH-1:0] m_sum   = '0;
    logic             m_cout  = 1'b0;
    int               m_byp   = 0;

    always @(posedge clk) begin
        if (rst) begin
            m_left  = 0;
            m_done  = 0;
            m_clean = 1;
        end else if (m_done) begin
            if (out_ready) m_done = 0;
        end else if (m_left > 0) begin
            m_left--;
            if (m_left == 0) m_done = 1;
        end else if (in_valid) begin
            {m_cout, m_sum} = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
            m_byp = 0;
            for (int unsigned i = 0; i < NIB; i++)
                if ((((a ^ b) >> (4 * i)) & 16'hF) == 16'hF) m_byp++;
            m_left  = NIB;
            m_clean = 0;
        end
        started = 1;
    end

    always @(negedge clk) begin
        if (started) begin
            chk("in_ready", {31'd0, in_ready}, {31'd0, (!m_done && m_left == 0)});
            chk("out_valid", {31'd0, out_valid}, {31'd0, m_done});
            if (m_done) begin
                chk("sum", {16'd0, sum}, {16'd0, m_sum});
                chk("cout", {31'd0, cout}, {31'd0, m_cout});
                chk("bypass_cnt", 32'(bypass_cnt), 32'(m_byp));
            end
            if (m_clean) begin
                chk("sum_after_rst", {16'd0, sum}, 32'd0);
                chk("cout_after_rst", {31'd0, cout}, 32'd0);
                chk("byp_after_rst", 32'(bypass_cnt), 32'd0);
            end
        end
    end

    task automatic run_op(input string nm, input logic [15:0] ta, input logic [15:0] tb_v,
                          input logic tc, input int hold, input bit noise,
                          input logic [15:0] esum, input logic ecout, input int ebyp);
        int lat;
        bit seen;
        @(negedge clk);
        chk({nm, "_ready_pre"}, {31'd0, in_ready}, 32'd1);
        a = ta; b = tb_v; cin = tc; in_valid = 1'b1;
        @(posedge clk);
        lat  = 0;
        seen = 0;
        @(negedge clk);
        for (int k = 0; k < 20 && !seen; k++) begin
            if (noise && k < 2) begin
                in_valid  = 1'b1;
                a         = 16'($urandom);
                b         = 16'($urandom);
                cin       = 1'($urandom);
                out_ready = 1'b1;
            end else begin
                in_valid  = 1'b0;
                out_ready = 1'b0;
            end
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (out_valid) seen = 1;
        end
        chk({nm, "_timeout"}, {31'd0, seen}, 32'd1);
        chk({nm, "_latency"}, 32'(lat), 32'(NIB));
        chk({nm, "_sum_lit"}, {16'd0, sum}, {16'd0, esum});
        chk({nm, "_cout_lit"}, {31'd0, cout}, {31'd0, ecout});
        chk({nm, "_byp_lit"}, 32'(bypass_cnt), 32'(ebyp));
        for (int h = 0; h < hold; h++) begin
            chk({nm, "_hold_ready"}, {31'd0, in_ready}, 32'd0);
            chk({nm, "_hold_sum"}, {16'd0, sum}, {16'd0, esum});
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        chk({nm, "_idle_ready"}, {31'd0, in_ready}, 32'd1);
        chk({nm, "_idle_valid"}, {31'd0, out_valid}, 32'd0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("reset_ready", {31'd0, in_ready}, 32'd1);
        chk("reset_valid", {31'd0, out_valid}, 32'd0);
        chk("reset_sum", {16'd0, sum}, 32'd0);

        run_op("all_prop_cin1", 16'h0F0F, 16'hF0F0, 1'b1, 0, 0, 16'h0000, 1'b1, 4);
        run_op("ffff_plus_1",   16'hFFFF, 16'h0001, 1'b0, 0, 0, 16'h0000, 1'b1, 3);
        run_op("stall_5",       16'h1234, 16'h4321, 1'b0, 5, 0, 16'h5555, 1'b0, 0);
        run_op("noise_in_run",  16'hA5A5, 16'h5A5A, 1'b0, 1, 1, 16'hFFFF, 1'b0, 4);
        run_op("msb_carry",     16'h8000, 16'h8000, 1'b0, 0, 0, 16'h0000, 1'b1, 0);
        run_op("all_prop_cin0", 16'h0F0F, 16'hF0F0, 1'b0, 0, 0, 16'hFFFF, 1'b0, 4);

        // Abort after two RUN cycles; no result may follow.
        @(negedge clk);
        a = 16'h1111; b = 16'h2222; cin = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("abort_ready", {31'd0, in_ready}, 32'd1);
        chk("abort_valid", {31'd0, out_valid}, 32'd0);
        chk("abort_sum", {16'd0, sum}, 32'd0);
        begin
            bit any_valid;
            any_valid = 0;
            repeat (8) begin
                @(negedge clk);
                if (out_valid) any_valid = 1;
            end
            chk("abort_no_result", {31'd0, any_valid}, 32'd0);
        end

        run_op("after_abort", 16'h0123, 16'h0456, 1'b1, 0, 0, 16'h057A, 1'b0, 0);

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
